mem_lsu_ctrl: RTL and testbench

MEM-stage load/store controller sitting between the EX/MEM pipeline register and the MEM/WB register. It turns one memory instruction per pipeline slot into a single request on the data-cache handshake bus, generates store byte strobes and replicated write data, and stalls the pipeline until the response returns. It delivers the raw 32-bit load word as `MEM_DMOut`, which the WB stage latches and sign/zero-extends. Only one transaction is outstanding at a time.

---
 rtl/mem_lsu_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_lsu_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu_ctrl.sv
// MEM-stage load/store controller: one outstanding data-cache request, store strobes/replication, pipeline stall.
// Optional alignment checking is enabled by defining LSU_ADDR_CHECK_EN.
module mem_lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_Flush,
  input  logic        MEM_Wr,
  input  logic        MEM_MemReq,
  input  logic        MEM_IsStore,
  input  logic [1:0]  MEM_Size,
  input  logic [31:0] MEM_Addr,
  input  logic [31:0] MEM_WData,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] MEM_DMOut,
  output logic        MEM_LsuStall,
  output logic        MEM_AdEL,
  output logic        MEM_AdES
);

  typedef enum logic [2:0] {IDLE, WAIT_ADDR, WAIT_DATA, HOLD, DRAIN} state_t;

  state_t      state;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] hold_data;
  logic [1:0]  req_size;
  logic [3:0]  req_wstrb;
  logic        req_wr;
  logic        fault;
  logic        launch;
  logic        done;
  logic [3:0]  strb_c;
  logic [31:0] wdata_c;

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    store_strb = 4'b0001 << a;
      2'd1:    store_strb = 4'b0011 << {a[1], 1'b0};
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    store_data = {4{d[7:0]}};
      2'd1:    store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

`ifdef LSU_ADDR_CHECK_EN
  // Size 3 is handled as a word, so MEM_Size[1] selects the word alignment rule.
  assign fault    = ((MEM_Size == 2'd1) & MEM_Addr[0]) | (MEM_Size[1] & (|MEM_Addr[1:0]));
  assign MEM_AdEL = fault & MEM_MemReq & ~MEM_Flush & ~MEM_IsStore;
  assign MEM_AdES = fault & MEM_MemReq & ~MEM_Flush & MEM_IsStore;
`else
  assign fault    = 1'b0;
  assign MEM_AdEL = 1'b0;
  assign MEM_AdES = 1'b0;
`endif

  assign strb_c  = store_strb(MEM_Size, MEM_Addr[1:0]);
  assign wdata_c = store_data(MEM_Size, MEM_WData);
  assign launch  = (state == IDLE) & MEM_MemReq & ~fault & ~MEM_Flush;
  assign done    = ((state == WAIT_DATA) & data_data_ok) | (state == HOLD);

  // Request is presented straight from the pipeline on launch, then from the request register.
  always_comb begin
    data_req   = launch | (state == WAIT_ADDR);
    data_wr    = req_wr;
    data_size  = req_size;
    data_addr  = req_addr;
    data_wstrb = req_wstrb;
    data_wdata = req_wdata;
    if (state == IDLE) begin
      data_wr    = MEM_IsStore;
      data_size  = MEM_Size;
      data_addr  = MEM_Addr;
      data_wstrb = MEM_IsStore ? strb_c : 4'b0000;
      data_wdata = wdata_c;
    end
  end

  assign MEM_LsuStall = (MEM_MemReq & ~MEM_Flush & ~fault & ~done) | (state == DRAIN);
  assign MEM_DMOut    = ((state == WAIT_DATA) & data_data_ok) ? data_rdata : hold_data;

  always_ff @(posedge clk) begin
    if (launch) begin
      req_addr  <= MEM_Addr;
      req_size  <= MEM_Size;
      req_wr    <= MEM_IsStore;
      req_wstrb <= MEM_IsStore ? strb_c : 4'b0000;
      req_wdata <= wdata_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) state <= data_addr_ok ? WAIT_DATA : WAIT_ADDR;
        end
        WAIT_ADDR: begin
          // An accepted request must still be drained even if flushed in the same cycle.
          if (data_addr_ok)   state <= MEM_Flush ? DRAIN : WAIT_DATA;
          else if (MEM_Flush) state <= IDLE;
        end
        WAIT_DATA: begin
          if (data_data_ok) begin
            if (!MEM_Flush) hold_data <= data_rdata;
            state <= (MEM_Flush | MEM_Wr) ? IDLE : HOLD;
          end else if (MEM_Flush) begin
            state <= DRAIN;
          end
        end
        HOLD: begin
          if (MEM_Wr | MEM_Flush) state <= IDLE;
        end
        DRAIN: begin
          if (data_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Directed-vector scoreboard bench for mem_lsu_ctrl; accepted requests and retired loads are checked by a monitor.
module tb_mem_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_Flush, MEM_Wr, MEM_MemReq, MEM_IsStore;
  logic [1:0]  MEM_Size;
  logic [31:0] MEM_Addr, MEM_WData;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata, MEM_DMOut;
  logic        MEM_LsuStall, MEM_AdEL, MEM_AdES;
  logic        hold_pipe;
  logic        fault_slot;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] res_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // The rest of the pipeline advances whenever the LSU is not stalling and no other source holds it.
  assign MEM_Wr = ~hold_pipe & ~MEM_LsuStall;

  mem_lsu_ctrl dut (
    .clk(clk), .rst(rst), .MEM_Flush(MEM_Flush), .MEM_Wr(MEM_Wr),
    .MEM_MemReq(MEM_MemReq), .MEM_IsStore(MEM_IsStore), .MEM_Size(MEM_Size),
    .MEM_Addr(MEM_Addr), .MEM_WData(MEM_WData), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .MEM_DMOut(MEM_DMOut),
    .MEM_LsuStall(MEM_LsuStall), .MEM_AdEL(MEM_AdEL), .MEM_AdES(MEM_AdES)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                          input logic [3:0] strb, input logic [31:0] wd);
    req_t r;
    r.addr = a; r.wr = wr; r.size = sz; r.wstrb = strb; r.wdata = wd;
    req_q.push_back(r);
  endtask

  task automatic drv(input logic st, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    MEM_MemReq = 1'b1; MEM_IsStore = st; MEM_Size = sz; MEM_Addr = a; MEM_WData = wd;
  endtask

  task automatic idle();
    MEM_MemReq = 1'b0; MEM_IsStore = 1'b0; MEM_Size = 2'd0; MEM_Addr = 32'd0; MEM_WData = 32'd0;
    MEM_Flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: accepted requests and retiring loads are compared against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_req && data_addr_ok) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected: got addr %h expected no request", data_addr);
        end else begin
          req_t r;
          r = req_q.pop_front();
          chk("req_addr", data_addr, r.addr);
          chk("req_wr", 32'(data_wr), 32'(r.wr));
          chk("req_size", 32'(data_size), 32'(r.size));
          chk("req_wstrb", 32'(data_wstrb), 32'(r.wstrb));
          if (r.wr) chk("req_wdata", data_wdata, r.wdata);
        end
      end
      if (MEM_MemReq && !MEM_IsStore && !MEM_Flush && MEM_Wr && !fault_slot) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL load_unexpected: got DMOut %h expected no retirement", MEM_DMOut);
        end else begin
          chk("load_dmout", MEM_DMOut, res_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; hold_pipe = 1'b0; fault_slot = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    at_neg();
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_stall", 32'(MEM_LsuStall), 32'd0);
    chk("rst_adel", 32'(MEM_AdEL), 32'd0);
    chk("rst_ades", 32'(MEM_AdES), 32'd0);
    chk("rst_dmout", MEM_DMOut, 32'd0);
    next_cyc();

    // Word load, best case: one stall cycle
    drv(1'b0, 2'd2, 32'h0000_0100, 32'd0); data_addr_ok = 1'b1;
    push_req(32'h0000_0100, 1'b0, 2'd2, 4'b0000, 32'd0);
    at_neg();
    chk("ld_req", 32'(data_req), 32'd1);
    chk("ld_stall_c1", 32'(MEM_LsuStall), 32'd1);
    next_cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    res_q.push_back(32'hDEAD_BEEF);
    at_neg();
    chk("ld_stall_c2", 32'(MEM_LsuStall), 32'd0);
    chk("ld_bypass", MEM_DMOut, 32'hDEAD_BEEF);
    next_cyc();
    idle();

    // Byte store to 0x103
    drv(1'b1, 2'd0, 32'h0000_0103, 32'h0000_005A); data_addr_ok = 1'b1;
    push_req(32'h0000_0103, 1'b1, 2'd0, 4'b1000, 32'h5A5A_5A5A);
    at_neg();
    chk("sb_stall_c1", 32'(MEM_LsuStall), 32'd1);
    next_cyc();
    data_addr_ok = 1'b0;
    at_neg();
    chk("sb_stall_c2", 32'(MEM_LsuStall), 32'd1);
    chk("sb_req_dropped", 32'(data_req), 32'd0);
    next_cyc();
    data_data_ok = 1'b1;
    at_neg();
    chk("sb_stall_c3", 32'(MEM_LsuStall), 32'd0);
    next_cyc();
    idle();

    // Half store to 0x102, addr_ok delayed three cycles; fields come from the request register
    drv(1'b1, 2'd1, 32'h0000_0102, 32'hAAAA_BEEF);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        MEM_Addr = 32'hFFFF_FFF0; MEM_WData = 32'd0;
      end
      if (i == 3) begin
        data_addr_ok = 1'b1;
        push_req(32'h0000_0102, 1'b1, 2'd1, 4'b1100, 32'hBEEF_BEEF);
      end
      at_neg();
      chk("sh_req_held", 32'(data_req), 32'd1);
      chk("sh_addr_held", data_addr, 32'h0000_0102);
      chk("sh_wstrb_held", 32'(data_wstrb), 32'h0000_000C);
      chk("sh_wdata_held", data_wdata, 32'hBEEF_BEEF);
      chk("sh_stall", 32'(MEM_LsuStall), 32'd1);
      next_cyc();
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    at_neg();
    chk("sh_stall_done", 32'(MEM_LsuStall), 32'd0);
    next_cyc();
    idle();

    // Flush in WAIT_DATA: drain the stale response before the next load issues
    drv(1'b0, 2'd2, 32'h0000_0200, 32'd0); data_addr_ok = 1'b1;
    push_req(32'h0000_0200, 1'b0, 2'd2, 4'b0000, 32'd0);
    at_neg();
    next_cyc();
    data_addr_ok = 1'b0; MEM_Flush = 1'b1;
    at_neg();
    chk("fl_stall_flushed", 32'(MEM_LsuStall), 32'd0);
    next_cyc();
    MEM_Flush = 1'b0; drv(1'b0, 2'd2, 32'h0000_0300, 32'd0);
    at_neg();
    chk("drain_stall", 32'(MEM_LsuStall), 32'd1);
    chk("drain_no_req", 32'(data_req), 32'd0);
    next_cyc();
    data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
    at_neg();
    chk("drain_no_req_dok", 32'(data_req), 32'd0);
    chk("drain_stall_dok", 32'(MEM_LsuStall), 32'd1);
    chk("drain_discard", MEM_DMOut, 32'd0);
    next_cyc();
    data_data_ok = 1'b0; data_rdata = 32'd0; data_addr_ok = 1'b1;
    push_req(32'h0000_0300, 1'b0, 2'd2, 4'b0000, 32'd0);
    at_neg();
    chk("after_drain_req", 32'(data_req), 32'd1);
    chk("after_drain_dmout", MEM_DMOut, 32'd0);
    next_cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    res_q.push_back(32'h1234_5678);
    at_neg();
    next_cyc();
    idle();

    // Load completes while the pipeline is held elsewhere for three cycles
    drv(1'b0, 2'd2, 32'h0000_0400, 32'd0); data_addr_ok = 1'b1;
    push_req(32'h0000_0400, 1'b0, 2'd2, 4'b0000, 32'd0);
    at_neg();
    next_cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; hold_pipe = 1'b1;
    at_neg();
    chk("hold_stall_c1", 32'(MEM_LsuStall), 32'd0);
    next_cyc();
    for (int i = 0; i < 2; i++) begin
      data_data_ok = (i == 0); data_rdata = (i == 0) ? 32'h1111_1111 : 32'd0;
      at_neg();
      chk("hold_stall", 32'(MEM_LsuStall), 32'd0);
      chk("hold_no_req", 32'(data_req), 32'd0);
      chk("hold_dmout", MEM_DMOut, 32'hCAFE_F00D);
      next_cyc();
    end
    hold_pipe = 1'b0;
    res_q.push_back(32'hCAFE_F00D);
    at_neg();
    chk("hold_release_no_req", 32'(data_req), 32'd0);
    next_cyc();
    idle();

    // Flush in WAIT_ADDR withdraws the request; flush with data_ok discards the data
    drv(1'b0, 2'd2, 32'h0000_0500, 32'd0);
    at_neg();
    chk("wa_req", 32'(data_req), 32'd1);
    chk("wa_stall", 32'(MEM_LsuStall), 32'd1);
    next_cyc();
    MEM_Flush = 1'b1;
    at_neg();
    chk("wa_flush_stall", 32'(MEM_LsuStall), 32'd0);
    next_cyc();
    MEM_Flush = 1'b0; drv(1'b0, 2'd2, 32'h0000_0600, 32'd0); data_addr_ok = 1'b1;
    push_req(32'h0000_0600, 1'b0, 2'd2, 4'b0000, 32'd0);
    at_neg();
    chk("wa_relaunch_req", 32'(data_req), 32'd1);
    next_cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h7777_7777; MEM_Flush = 1'b1;
    at_neg();
    chk("fl_dok_stall", 32'(MEM_LsuStall), 32'd0);
    next_cyc();
    idle();
    at_neg();
    chk("fl_dok_discard", MEM_DMOut, 32'hCAFE_F00D);
    chk("fl_dok_idle", 32'(data_req), 32'd0);
    next_cyc();

    // Misaligned word load at 0x102
`ifdef LSU_ADDR_CHECK_EN
    drv(1'b0, 2'd2, 32'h0000_0102, 32'd0); fault_slot = 1'b1;
    at_neg();
    chk("adel", 32'(MEM_AdEL), 32'd1);
    chk("adel_no_req", 32'(data_req), 32'd0);
    chk("adel_no_stall", 32'(MEM_LsuStall), 32'd0);
    next_cyc();
    drv(1'b1, 2'd1, 32'h0000_0101, 32'd0);
    at_neg();
    chk("ades", 32'(MEM_AdES), 32'd1);
    chk("ades_no_req", 32'(data_req), 32'd0);
    next_cyc();
    fault_slot = 1'b0;
    idle();
`else
    drv(1'b0, 2'd2, 32'h0000_0102, 32'd0); data_addr_ok = 1'b1;
    push_req(32'h0000_0102, 1'b0, 2'd2, 4'b0000, 32'd0);
    at_neg();
    chk("mis_adel", 32'(MEM_AdEL), 32'd0);
    chk("mis_req", 32'(data_req), 32'd1);
    next_cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
    res_q.push_back(32'h0BAD_F00D);
    at_neg();
    chk("mis_stall_done", 32'(MEM_LsuStall), 32'd0);
    next_cyc();
    idle();
`endif

    at_neg();
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
